// File: rtl/panda_pkg.sv
// Shared types and constants for the Panda single-cycle core:
// ALU operators, load/store width codes and write-back source codes.
package panda_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_XOR,
    ALU_OR,
    ALU_AND,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_LT,
    ALU_LTU,
    ALU_GE,
    ALU_GEU,
    ALU_EQ,
    ALU_NE
  } alu_operator_e;

  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

  localparam logic [1:0] RD_SEL_ALU     = 2'b00;
  localparam logic [1:0] RD_SEL_LOAD    = 2'b01;
  localparam logic [1:0] RD_SEL_PC_NEXT = 2'b10;
  localparam logic [1:0] RD_SEL_IMM     = 2'b11;

endpackage

// File: rtl/panda_alu.sv
// Combinational RV32I ALU; comparison operators return 0 or 1 in a full
// 32-bit result so bit 0 can serve directly as the branch condition.
module panda_alu
  import panda_pkg::*;
(
  input  logic [31:0]   operand_a_i,
  input  logic [31:0]   operand_b_i,
  input  alu_operator_e operator_i,
  output logic [31:0]   result_o
);

  logic [4:0] shamt;
  logic       lt_signed;
  logic       lt_unsigned;

  assign shamt       = operand_b_i[4:0];
  assign lt_signed   = $signed(operand_a_i) < $signed(operand_b_i);
  assign lt_unsigned = operand_a_i < operand_b_i;

  always_comb begin
    result_o = '0;
    case (operator_i)
      ALU_ADD: result_o = operand_a_i + operand_b_i;
      ALU_SUB: result_o = operand_a_i - operand_b_i;
      ALU_XOR: result_o = operand_a_i ^ operand_b_i;
      ALU_OR:  result_o = operand_a_i | operand_b_i;
      ALU_AND: result_o = operand_a_i & operand_b_i;
      ALU_SLL: result_o = operand_a_i << shamt;
      ALU_SRL: result_o = operand_a_i >> shamt;
      ALU_SRA: result_o = $unsigned($signed(operand_a_i) >>> shamt);
      ALU_LT:  result_o = {31'b0, lt_signed};
      ALU_LTU: result_o = {31'b0, lt_unsigned};
      ALU_GE:  result_o = {31'b0, ~lt_signed};
      ALU_GEU: result_o = {31'b0, ~lt_unsigned};
      ALU_EQ:  result_o = {31'b0, operand_a_i == operand_b_i};
      ALU_NE:  result_o = {31'b0, operand_a_i != operand_b_i};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/panda_sc_datapath.sv
// Panda single-cycle datapath: register file, ALU operand muxes, load/store
// lane alignment, write-back mux and the dedicated jump-target adder.
module panda_sc_datapath
  import panda_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [4:0]    rs1_addr_i,
  input  logic [4:0]    rs2_addr_i,
  input  logic [4:0]    rd_addr_i,
  input  logic          rd_we_i,
  input  logic          sel_operand_a_i,
  input  logic          sel_operand_b_i,
  input  logic [1:0]    sel_rd_data_i,
  input  alu_operator_e alu_operator_i,
  input  logic          load_store_i,
  input  logic [1:0]    load_store_width_i,
  input  logic          load_unsigned_i,
  input  logic [31:0]   data_rdata_i,
  output logic [31:0]   data_wdata_o,
  output logic [31:0]   data_addr_o,
  output logic [3:0]    data_we_o,
  input  logic [31:0]   pc_i,
  input  logic [31:0]   pc_next_i,
  input  logic [31:0]   imm_i,
  output logic [31:0]   jump_target_o,
  output logic          branch_cond_o
);

  logic [31:0] rf_q [32];
  logic [31:0] rd_data_d;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] alu_result;
  logic [31:0] load_data;
  logic [7:0]  rdata_byte [4];
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // Entry 0 is never written, so x0 stays zero; reads still force it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rd_we_i && (rd_addr_i != 5'd0)) begin
      rf_q[rd_addr_i] <= rd_data_d;
    end
  end

  assign rs1_data = (rs1_addr_i == 5'd0) ? 32'd0 : rf_q[rs1_addr_i];
  assign rs2_data = (rs2_addr_i == 5'd0) ? 32'd0 : rf_q[rs2_addr_i];

  assign operand_a = sel_operand_a_i ? pc_i  : rs1_data;
  assign operand_b = sel_operand_b_i ? imm_i : rs2_data;

  panda_alu u_alu (
    .operand_a_i (operand_a),
    .operand_b_i (operand_b),
    .operator_i  (alu_operator_i),
    .result_o    (alu_result)
  );

  assign data_addr_o   = alu_result;
  assign branch_cond_o = alu_result[0];
  assign jump_target_o = pc_i + imm_i;

  // Store data is replicated across lanes so memory only needs the byte enables.
  always_comb begin
    data_we_o    = 4'b0000;
    data_wdata_o = rs2_data;
    case (load_store_width_i)
      LS_BYTE: begin
        data_wdata_o = {4{rs2_data[7:0]}};
        data_we_o    = 4'b0001 << alu_result[1:0];
      end
      LS_HALF: begin
        data_wdata_o = {2{rs2_data[15:0]}};
        data_we_o    = alu_result[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        data_wdata_o = rs2_data;
        data_we_o    = 4'b1111;
      end
    endcase
    if (!load_store_i) data_we_o = 4'b0000;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_rdata_lane
    assign rdata_byte[gi] = data_rdata_i[8*gi +: 8];
  end

  assign load_byte = rdata_byte[alu_result[1:0]];
  assign load_half = alu_result[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];

  always_comb begin
    load_data = data_rdata_i;
    case (load_store_width_i)
      LS_BYTE: load_data = load_unsigned_i ? {24'd0, load_byte}
                                           : {{24{load_byte[7]}}, load_byte};
      LS_HALF: load_data = load_unsigned_i ? {16'd0, load_half}
                                           : {{16{load_half[15]}}, load_half};
      default: load_data = data_rdata_i;
    endcase
  end

  always_comb begin
    rd_data_d = alu_result;
    case (sel_rd_data_i)
      RD_SEL_ALU:     rd_data_d = alu_result;
      RD_SEL_LOAD:    rd_data_d = load_data;
      RD_SEL_PC_NEXT: rd_data_d = pc_next_i;
      default:        rd_data_d = imm_i;
    endcase
  end

endmodule

// File: tb/tb_panda_sc_datapath.sv
// Directed bench for panda_sc_datapath: expected values go into a scoreboard
// queue as each step is driven and are popped when the outputs are sampled.
module tb_panda_sc_datapath;
  import panda_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    rs1, rs2, rd;
  logic          rd_we, sel_a, sel_b;
  logic [1:0]    sel_rd;
  alu_operator_e alu_op;
  logic          ls;
  logic [1:0]    ls_width;
  logic          ld_uns;
  logic [31:0]   rdata, imm;
  logic [31:0]   pc, pc_next;
  logic [31:0]   wdata_o, addr_o, jt_o;
  logic [3:0]    we_o;
  logic          br_o;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= 32'd0;
    else        pc <= pc + 32'd4;
  end
  assign pc_next = pc + 32'd4;

  panda_sc_datapath dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .rs1_addr_i         (rs1),
    .rs2_addr_i         (rs2),
    .rd_addr_i          (rd),
    .rd_we_i            (rd_we),
    .sel_operand_a_i    (sel_a),
    .sel_operand_b_i    (sel_b),
    .sel_rd_data_i      (sel_rd),
    .alu_operator_i     (alu_op),
    .load_store_i       (ls),
    .load_store_width_i (ls_width),
    .load_unsigned_i    (ld_uns),
    .data_rdata_i       (rdata),
    .data_wdata_o       (wdata_o),
    .data_addr_o        (addr_o),
    .data_we_o          (we_o),
    .pc_i               (pc),
    .pc_next_i          (pc_next),
    .imm_i              (imm),
    .jump_target_o      (jt_o),
    .branch_cond_o      (br_o)
  );

  task automatic defaults();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; rd_we = 1'b0;
    sel_a = 1'b0; sel_b = 1'b0; sel_rd = RD_SEL_ALU; alu_op = ALU_ADD;
    ls = 1'b0; ls_width = LS_WORD; ld_uns = 1'b0; rdata = 32'd0; imm = 32'd0;
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL %s: observed 0x%08h but scoreboard empty", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        fails++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
    end
    $display("[TB] %s obs=0x%08h", tag, obs);
  endtask

  // Starts a new cycle just after the edge with all controls at defaults.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    defaults();
  endtask

  task automatic read_reg(input logic [4:0] r, input logic [31:0] v, input string tag);
    next_cycle();
    rs1 = r; sel_b = 1'b1; imm = 32'd0;
    expect_val(v);
    @(negedge clk);
    check(tag, addr_o);
  endtask

  typedef struct packed {
    logic [31:0] imm;
    logic [1:0]  width;
    logic [3:0]  we;
    logic [31:0] wdata;
  } store_vec_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [1:0]  width;
    logic        uns;
    logic [31:0] result;
  } load_vec_t;

  typedef struct packed {
    alu_operator_e op;
    logic [31:0]   result;
  } alu_vec_t;

  store_vec_t st_tbl [5];
  load_vec_t  ld_tbl [6];
  alu_vec_t   alu_tbl [8];

  initial begin
    rst_n = 1'b0;
    defaults();
    rs1 = 5'd1; sel_b = 1'b1; ls = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    expect_val(32'd0); check("reset_x1_read", addr_o);
    expect_val(32'd0); check("reset_we", {28'd0, we_o});

    // ADDI x1 = x0 + 10 (pc = 0 on the first post-reset cycle)
    @(posedge clk); #1;
    rst_n = 1'b1; defaults();
    rd = 5'd1; rd_we = 1'b1; sel_b = 1'b1; imm = 32'd10;
    expect_val(32'd10);
    @(negedge clk); check("addi_x1_alu", addr_o);

    next_cycle();
    rd = 5'd2; rd_we = 1'b1; sel_b = 1'b1; imm = 32'd15;
    expect_val(32'd15);
    @(negedge clk); check("addi_x2_alu", addr_o);

    // JAL at pc = 8
    next_cycle();
    sel_a = 1'b1; sel_b = 1'b1; imm = 32'd12; sel_rd = RD_SEL_PC_NEXT;
    rd = 5'd3; rd_we = 1'b1;
    expect_val(32'd20); expect_val(32'd20);
    @(negedge clk);
    check("jal_jump_target", jt_o);
    check("jal_alu_pc_imm", addr_o);

    next_cycle();
    rd = 5'd0; rd_we = 1'b1; sel_b = 1'b1; imm = 32'd99;
    @(negedge clk);

    read_reg(5'd1, 32'd10, "read_x1");
    read_reg(5'd2, 32'd15, "read_x2");
    read_reg(5'd3, 32'd12, "read_x3_link");
    read_reg(5'd0, 32'd0,  "read_x0_after_write");

    // Read-during-write: old value until the edge, new value after it
    next_cycle();
    rs1 = 5'd2; rd = 5'd2; rd_we = 1'b1; sel_b = 1'b1; imm = 32'd1;
    expect_val(32'd16);
    @(negedge clk); check("x2_before_edge", addr_o);
    @(posedge clk); #1;
    expect_val(32'd17);
    check("x2_after_edge", addr_o);
    defaults();

    next_cycle();
    rs1 = 5'd1; rd = 5'd4; rd_we = 1'b1; sel_b = 1'b1; imm = 32'd24;
    expect_val(32'd34);
    @(negedge clk); check("addi_x4", addr_o);

    next_cycle();
    rs1 = 5'd4; rs2 = 5'd3; alu_op = ALU_GE;
    expect_val(32'd1);
    @(negedge clk); check("ge_branch_cond", {31'd0, br_o});
    next_cycle();
    rs1 = 5'd4; rs2 = 5'd3; alu_op = ALU_LT;
    expect_val(32'd0);
    @(negedge clk); check("lt_branch_cond", {31'd0, br_o});

    // x4 = 34, x3 = 12
    alu_tbl = '{
      '{ALU_SUB, 32'd22},
      '{ALU_XOR, 32'h0000_002E},
      '{ALU_OR,  32'h0000_002E},
      '{ALU_AND, 32'h0000_0000},
      '{ALU_SLL, 32'h0002_2000},
      '{ALU_SRL, 32'h0000_0000},
      '{ALU_EQ,  32'd0},
      '{ALU_NE,  32'd1}
    };
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      rs1 = 5'd4; rs2 = 5'd3; alu_op = alu_tbl[i].op;
      expect_val(alu_tbl[i].result);
      @(negedge clk); check($sformatf("alu_%s", alu_tbl[i].op.name()), addr_o);
    end

    st_tbl = '{
      '{32'd16, LS_WORD, 4'b1111, 32'h0000_000A},
      '{32'd20, LS_HALF, 4'b0011, 32'h000A_000A},
      '{32'd22, LS_HALF, 4'b1100, 32'h000A_000A},
      '{32'd19, LS_BYTE, 4'b1000, 32'h0A0A_0A0A},
      '{32'd17, LS_BYTE, 4'b0010, 32'h0A0A_0A0A}
    };
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      rs1 = 5'd0; rs2 = 5'd1; sel_b = 1'b1; ls = 1'b1;
      imm = st_tbl[i].imm; ls_width = st_tbl[i].width;
      expect_val(st_tbl[i].imm);
      expect_val({28'd0, st_tbl[i].we});
      expect_val(st_tbl[i].wdata);
      @(negedge clk);
      check($sformatf("store%0d_addr", i), addr_o);
      check($sformatf("store%0d_we", i), {28'd0, we_o});
      check($sformatf("store%0d_wdata", i), wdata_o);
    end

    ld_tbl = '{
      '{5'd5,  32'd12, LS_HALF, 1'b0, 32'hFFFF_EF78},
      '{5'd6,  32'd12, LS_HALF, 1'b1, 32'h0000_EF78},
      '{5'd8,  32'd13, LS_BYTE, 1'b0, 32'hFFFF_FFEF},
      '{5'd9,  32'd15, LS_BYTE, 1'b1, 32'h0000_00AB},
      '{5'd10, 32'd14, LS_HALF, 1'b0, 32'hFFFF_ABCD},
      '{5'd11, 32'd12, LS_WORD, 1'b0, 32'hABCD_EF78}
    };
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      rdata = 32'hABCD_EF78; sel_b = 1'b1; sel_rd = RD_SEL_LOAD;
      rd = ld_tbl[i].rd; rd_we = 1'b1; imm = ld_tbl[i].imm;
      ls_width = ld_tbl[i].width; ld_uns = ld_tbl[i].uns;
      expect_val(32'd0);
      @(negedge clk); check($sformatf("load%0d_no_we", i), {28'd0, we_o});
    end
    for (int i = 0; i < 6; i++) begin
      read_reg(ld_tbl[i].rd, ld_tbl[i].result, $sformatf("load%0d_result", i));
    end

    // Signed operations on the negative value in x5
    next_cycle();
    rs1 = 5'd5; rs2 = 5'd3; alu_op = ALU_SRA;
    expect_val(32'hFFFF_FFFE);
    @(negedge clk); check("sra_negative", addr_o);
    next_cycle();
    rs1 = 5'd5; rs2 = 5'd3; alu_op = ALU_LT;
    expect_val(32'd1);
    @(negedge clk); check("lt_signed_neg", addr_o);
    next_cycle();
    rs1 = 5'd5; rs2 = 5'd3; alu_op = ALU_GEU;
    expect_val(32'd1);
    @(negedge clk); check("geu_unsigned_big", addr_o);

    // LUI x7
    next_cycle();
    sel_rd = RD_SEL_IMM; imm = 32'hABCD_E000; rd = 5'd7; rd_we = 1'b1;
    @(negedge clk);
    read_reg(5'd7, 32'hABCD_E000, "lui_x7");

    // Mid-cycle reset while a write of x1 is pending
    next_cycle();
    rs2 = 5'd7; ls = 1'b1; ls_width = LS_WORD;
    sel_rd = RD_SEL_IMM; imm = 32'h0000_0055; rd = 5'd1; rd_we = 1'b1;
    #1;
    expect_val(32'hABCD_E000); check("pre_reset_x7", wdata_o);
    #1;
    rst_n = 1'b0;
    #1;
    expect_val(32'd0); check("async_reset_x7", wdata_o);
    @(posedge clk); #1;
    rst_n = 1'b1;
    defaults();
    @(negedge clk);
    read_reg(5'd1, 32'd0, "no_write_in_reset_x1");
    read_reg(5'd4, 32'd0, "reset_cleared_x4");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/panda_sc_datapath.md
Name: panda_sc_datapath

Overview:
Single-cycle RV32I datapath for the Panda core. It contains:
- a 32x32 register file
- the ALU and its operand muxes
- the load/store data alignment path
- the write-back mux
- the branch/jump target logic

The controller supplies decoded control signals and the fetch stage supplies pc_i/pc_next_i. The block drives the data-memory interface and returns the branch condition and jump target.

Parameters:
none

Ports:
clk_i  in  1  clock; register-file writes on rising edge
rst_ni  in  1  asynchronous active-low reset
rs1_addr_i  in  5  source register 1 index
rs2_addr_i  in  5  source register 2 index
rd_addr_i  in  5  destination register index
rd_we_i  in  1  register write enable
sel_operand_a_i  in  1  ALU operand A: 0=rs1, 1=pc_i
sel_operand_b_i  in  1  ALU operand B: 0=rs2, 1=imm_i
sel_rd_data_i  in  2  write-back source: 00=ALU result, 01=load data, 10=pc_next_i, 11=imm_i
alu_operator_i  in  alu_operator_e  ALU operation (panda_pkg)
load_store_i  in  1  1=store access, 0=load/no store
load_store_width_i  in  2  00=byte, 01=half, 10=word (11 treated as word)
load_unsigned_i  in  1  1=zero-extend loads, 0=sign-extend
data_rdata_i  in  32  memory read data (word-aligned)
data_wdata_o  out  32  memory write data (lane-replicated)
data_addr_o  out  32  memory address = ALU result
data_we_o  out  4  byte write enables
pc_i  in  32  current PC
pc_next_i  in  32  PC+4 (link value)
imm_i  in  32  decoded immediate
jump_target_o  out  32  pc_i + imm_i
branch_cond_o  out  1  ALU result bit 0

Behaviour:
Register file:
- 32 x 32-bit registers with combinational reads.
- x0 always reads 0; writes to x0 are ignored.
- On rst_ni low, all registers clear to 0 immediately.
- Write on posedge clk_i when rd_we_i=1 and rd_addr_i!=0.
- A read of a register written this cycle returns the old value until the edge.

ALU (combinational):
- ADD, SUB, XOR, OR, AND: standard 32-bit wrap-around arithmetic and logic.
- SLL, SRL, SRA: shift amount is B[4:0].
- LT, LTU, GE, GEU, EQ, NE: 32-bit result 0 or 1.

Derived outputs:
- branch_cond_o = alu_result[0].
- data_addr_o = alu_result at all times; this value is also the JALR target source for the controller.
- jump_target_o = pc_i + imm_i from a dedicated adder, independent of the ALU.

Store path:
- When load_store_i=0, data_we_o=0000.
- Byte: data_we_o = 0001 shifted left by addr[1:0]; data_wdata_o = rs2[7:0] replicated x4.
- Half: data_we_o = 1100 if addr[1] else 0011 (addr[0] ignored); data_wdata_o = rs2[15:0] replicated x2.
- Word: data_we_o = 1111 (addr[1:0] ignored); data_wdata_o = rs2.

Load path:
- Byte: select byte addr[1:0] of data_rdata_i.
- Half: select upper half if addr[1] else lower half.
- Word: full word.
- Sign- or zero-extend per load_unsigned_i.

Write-back and timing:
- rd write data is chosen by sel_rd_data_i.
- All outputs are combinational with no latency. Their reset value follows from cleared registers with current inputs.
- Reset asserted mid-operation clears the register file at once; no write occurs while rst_ni is low.

Decomposition:
- panda_pkg holds:
  - alu_operator_e (ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LT, ALU_LTU, ALU_GE, ALU_GEU, ALU_EQ, ALU_NE)
  - width constants (byte/half/word)
  - rd-data select constants
- One natural sub-module, panda_alu (operands a/b, operator in, 32-bit result out).
- Register file, muxes and load/store alignment stay in the datapath.

Test Plan:
Bench setup: 10 ns clock. PC register advances pc_i by 4 each cycle from 0 after reset. sel_rd_data_i=00, alu_operator_i=ALU_ADD, load_store_i=0 unless stated.
1. Register writes: ADDI x1=x0+10, then x2=x0+15 (rd_we=1, sel_b=1) -> x1=10, x2=15; writes to x0 leave it reading 0.
2. JAL at pc=8 (sel_a=1, sel_b=1, imm=12, sel_rd=10, rd=x3) -> jump_target_o=20, x3=12.
3. ADDI x4=x1+24 -> 34. With rs1=x4, rs2=x3, sel_a=0, sel_b=0, rd_we=0:
   - ALU_GE -> branch_cond_o=1
   - ALU_LT -> branch_cond_o=0
4. Stores with rs1=x0, rs2=x1, sel_b=1, load_store=1:
   - SW imm=16 -> addr 16, we=1111, wdata=0x0000000A
   - SH imm=20 -> we=0011, wdata=0x000A000A
   - SH imm=22 -> we=1100
   - SB at addr 19 -> we=1000, wdata=0x0A0A0A0A
5. Loads with data_rdata_i=0xABCDEF78, imm=12, sel_rd=01:
   - LH -> x5=0xFFFFEF78
   - LHU -> x6=0x0000EF78
   - LB at addr 13 -> 0xFFFFFFEF
6. LUI: sel_rd=11, imm=0xABCDE000 -> x7=0xABCDE000. Then assert rst_ni mid-cycle -> all registers read 0 immediately.
